// File: rtl/dlf16_pkg.sv
// DLFloat16 field layout, compare opcodes, arbiter FSM states and the
// compare / compare_out datapath functions shared by the FPU.
package dlf16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 9;
  localparam int MANT_W   = 9;

  localparam logic [1:0] CMP_LT = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_EQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_flags_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } cmp_req_t;

  // Sign-magnitude ordering; -0 sorts below +0 and there is no NaN/inf handling.
  function automatic cmp_flags_t dlf16_compare(input logic [15:0] a, input logic [15:0] b);
    cmp_flags_t f;
    logic sa, sb, mag_lt, mag_gt;
    logic [EXP_MSB-EXP_LSB:0] ea, eb;
    logic [MANT_W-1:0] ma, mb;
    sa = a[SIGN_BIT];
    sb = b[SIGN_BIT];
    ea = a[EXP_MSB:EXP_LSB];
    eb = b[EXP_MSB:EXP_LSB];
    ma = a[MANT_W-1:0];
    mb = b[MANT_W-1:0];
    mag_lt = (ea < eb) || ((ea == eb) && (ma < mb));
    mag_gt = (ea > eb) || ((ea == eb) && (ma > mb));
    f.eq = (a == b);
    if (sa != sb) begin
      f.lt = sa;
      f.gt = sb;
    end else if (sa) begin
      f.lt = mag_gt;
      f.gt = mag_lt;
    end else begin
      f.lt = mag_lt;
      f.gt = mag_gt;
    end
    return f;
  endfunction

  function automatic logic [15:0] dlf16_compare_out(input cmp_flags_t f, input logic [1:0] op);
    logic [15:0] r;
    case (op)
      CMP_LT:  r = {16{f.lt}};
      CMP_GT:  r = {16{f.gt}};
      CMP_EQ:  r = {16{f.eq}};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Shares one DLFloat16 compare datapath among NREQ requesters with round-robin
// grant, a registered compare stage and a tagged response held until accepted.
module fp_cmp_arbiter
  import dlf16_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  cmp_req_t       opnd_q, opnd_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            grant_en;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    opnd_d      = opnd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    grant_en    = 1'b0;
    case (state_q)
      ST_IDLE: grant_en = 1'b1;
      ST_EXEC: begin
        rsp_data_d  = dlf16_compare_out(dlf16_compare(opnd_q.a, opnd_q.b), opnd_q.op);
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          grant_en    = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A grant out of RESP overlaps the response hand-off to keep 1 op / 2 cycles.
    if (grant_en && arb_any) begin
      state_d   = ST_EXEC;
      ptr_d     = arb_idx;
      gid_d     = arb_idx;
      opnd_d.a  = req_a[16*arb_idx +: 16];
      opnd_d.b  = req_b[16*arb_idx +: 16];
      opnd_d.op = req_op[2*arb_idx +: 2];
    end
    req_ready = grant_en ? arb_gnt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDW'(NREQ-1);
      gid_q       <= '0;
      opnd_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      opnd_q      <= opnd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
